// File: rtl/vc_dest_arbiter.sv
// ---------------------------------------------------------------------------
// vc_dest_arbiter
//
// Purpose:
//   Sits between the VC0/VC1 show-ahead FIFO pair and the two destination
//   FIFOs (D0/D1) in the PCIe transmit path. Each cycle it grants at most one
//   virtual channel, with strict VC0 priority. It pops the granted head word
//   and pushes it, one cycle later, into the destination selected by data bit
//   DEST_BIT. A VC whose destination is almost full is not eligible, so VC1
//   can bypass a VC0 head that is stuck on a paused destination.
//
// Optional feature (macro VC_ARB_STARVE_GUARD_EN):
//   This adds a 3-bit starvation counter. After seven VC0 grants made while
//   VC1 was eligible and waiting, the next grant goes to VC1.
//   With the macro undefined, the block is pure strict priority.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   vc0_data/empty   VC0 FIFO head word / empty flag
//   vc1_data/empty   VC1 FIFO head word / empty flag
//   d0_almost_full   D0 pause request
//   d1_almost_full   D1 pause request
//   vc0_pop/vc1_pop  combinational pop strobes (equal to this cycle's grant)
//   d0_push/d0_data  registered write strobe and word for D0
//   d1_push/d1_data  registered write strobe and word for D1
//   last_grant       registered grant state: 00 IDLE, 01 VC0, 10 VC1
// ---------------------------------------------------------------------------
module vc_dest_arbiter #(
    parameter int data_width = 6,
    parameter int DEST_BIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] vc0_data,
    input  logic                  vc0_empty,
    input  logic [data_width-1:0] vc1_data,
    input  logic                  vc1_empty,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic [data_width-1:0] d0_data,
    output logic                  d1_push,
    output logic [data_width-1:0] d1_data,
    output logic [1:0]            last_grant
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GRANT_VC0 = 2'b01,
        GRANT_VC1 = 2'b10
    } grant_state_t;

    grant_state_t          state;
    logic                  vc0_dest;
    logic                  vc1_dest;
    logic                  vc0_elig;
    logic                  vc1_elig;
    logic                  grant_vc0;
    logic                  grant_vc1;
    logic                  grant_any;
    logic                  grant_dest;
    logic [data_width-1:0] grant_word;
    logic                  force_vc1;

    assign vc0_dest = vc0_data[DEST_BIT];
    assign vc1_dest = vc1_data[DEST_BIT];

    // A VC is eligible when its head exists and the destination it targets is
    // not paused. Reset masks eligibility, so no pop escapes while reset is high.
    always_comb begin
        vc0_elig = 1'b0;
        vc1_elig = 1'b0;
        if (!reset) begin
            vc0_elig = !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
            vc1_elig = !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);
        end
    end

`ifdef VC_ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    // When VC1 has lost seven times in a row while eligible, it wins once.
    assign force_vc1 = (starve_cnt == 3'd7) && vc1_elig;

    // Count VC0 wins that kept an eligible VC1 waiting. Any VC1 grant clears
    // the count. The counter cannot wrap, because at 7 with VC1 eligible the
    // grant goes to VC1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 3'd0;
        end else if (grant_vc1) begin
            starve_cnt <= 3'd0;
        end else if (grant_vc0 && vc1_elig) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign force_vc1 = 1'b0;
`endif

    // Strict VC0 priority, unless the starvation guard forces a VC1 turn.
    always_comb begin
        grant_vc0 = vc0_elig && !force_vc1;
        grant_vc1 = vc1_elig && !grant_vc0;
        grant_any = grant_vc0 || grant_vc1;
    end

    assign vc0_pop    = grant_vc0;
    assign vc1_pop    = grant_vc1;
    assign grant_word = grant_vc1 ? vc1_data : vc0_data;
    assign grant_dest = grant_vc1 ? vc1_dest : vc0_dest;

    // Output register and grant state. The data register of the destination
    // that is not written keeps its previous word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d0_push <= 1'b0;
            d1_push <= 1'b0;
            d0_data <= '0;
            d1_data <= '0;
            state   <= IDLE;
        end else begin
            d0_push <= grant_any && !grant_dest;
            d1_push <= grant_any && grant_dest;
            if (grant_any && !grant_dest) begin
                d0_data <= grant_word;
            end
            if (grant_any && grant_dest) begin
                d1_data <= grant_word;
            end
            if (grant_vc0) begin
                state <= GRANT_VC0;
            end else if (grant_vc1) begin
                state <= GRANT_VC1;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign last_grant = state;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_dest_arbiter
//
// This bench models the VC0/VC1 FIFOs as queues. It keeps an abstract
// reference of the grant rules and of the registered destination outputs.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_vc_dest_arbiter;

    localparam int W  = 6;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] vc0_data = '0;
    logic [W-1:0] vc1_data = '0;
    logic         vc0_empty = 1'b1;
    logic         vc1_empty = 1'b1;
    logic         d0_almost_full = 1'b0;
    logic         d1_almost_full = 1'b0;
    logic         vc0_pop, vc1_pop, d0_push, d1_push;
    logic [W-1:0] d0_data, d1_data;
    logic [1:0]   last_grant;

    int checks = 0;
    int errors = 0;

    // Reference state: source queues, pause flags, the expected grant for this
    // cycle, and the expected registered outputs.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         af0 = 1'b0;
    logic         af1 = 1'b0;
    int           exp_g = 0;
    logic         m_e1 = 1'b0;
    logic         m_d0_push = 1'b0;
    logic         m_d1_push = 1'b0;
    logic [W-1:0] m_d0_data = '0;
    logic [W-1:0] m_d1_data = '0;
    logic [1:0]   m_last = 2'b00;
    int           m_wait = 0;

    vc_dest_arbiter #(.data_width(W), .DEST_BIT(DB)) dut (
        .clk(clk), .reset(reset),
        .vc0_data(vc0_data), .vc0_empty(vc0_empty),
        .vc1_data(vc1_data), .vc1_empty(vc1_empty),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d0_data(d0_data),
        .d1_push(d1_push), .d1_data(d1_data),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Present the queue heads to the DUT and decide this cycle's grant.
    // An empty VC shows garbage data.
    task automatic drive();
        logic e0;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = vc0_empty ? W'($urandom) : q0[0];
        vc1_data  = vc1_empty ? W'($urandom) : q1[0];
        d0_almost_full = af0;
        d1_almost_full = af1;
        e0   = !vc0_empty && !(vc0_data[DB] ? af1 : af0);
        m_e1 = !vc1_empty && !(vc1_data[DB] ? af1 : af0);
        if (reset) exp_g = 0;
`ifdef VC_ARB_STARVE_GUARD_EN
        else if (m_wait == 7 && m_e1) exp_g = 2;
`endif
        else if (e0) exp_g = 1;
        else if (m_e1) exp_g = 2;
        else exp_g = 0;
    endtask

    // Take the rising edge, move the granted word into the expected outputs,
    // then present the next inputs.
    task automatic advance();
        logic [W-1:0] w;
        @(posedge clk);
        m_d0_push = 1'b0;
        m_d1_push = 1'b0;
        if (reset) begin
            m_d0_data = '0; m_d1_data = '0; m_last = 2'b00; m_wait = 0;
        end else begin
            if (exp_g != 0) begin
                if (exp_g == 1) w = q0.pop_front();
                else            w = q1.pop_front();
                if (w[DB]) begin m_d1_push = 1'b1; m_d1_data = w; end
                else       begin m_d0_push = 1'b1; m_d0_data = w; end
            end
            m_last = (exp_g == 1) ? 2'b01 : (exp_g == 2) ? 2'b10 : 2'b00;
            if (exp_g == 2) m_wait = 0;
            else if (exp_g == 1 && m_e1) m_wait = m_wait + 1;
        end
        #1;
        drive();
    endtask

    task automatic drain();
        af0 = 1'b0; af1 = 1'b0;
        drive();
        for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) advance();
        advance();
    endtask

    task automatic test_reset();
        q0.push_back(6'b000011);
        q1.push_back(6'b010101);
        drive();
        advance(); advance();
        @(negedge clk);
        checks++; if (vc0_pop !== 1'b0 || vc1_pop !== 1'b0) begin errors++; $display("[TB] FAIL reset_pop got %b%b exp 00", vc0_pop, vc1_pop); end
        checks++; if (d0_push !== 1'b0 || d1_push !== 1'b0) begin errors++; $display("[TB] FAIL reset_push got %b%b exp 00", d0_push, d1_push); end
        checks++; if (d0_data !== 6'd0 || d1_data !== 6'd0) begin errors++; $display("[TB] FAIL reset_data got %b %b exp 0 0", d0_data, d1_data); end
        checks++; if (last_grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_last got %b exp 00", last_grant); end
        advance();
        reset = 1'b0;
        q0.delete(); q1.delete();
        drive();
    endtask

    task automatic test_basic();
        q0.push_back(6'b000001);
        q0.push_back(6'b000010);
        drive();
        @(negedge clk);
        checks++; if (vc0_pop !== 1'b1 || vc1_pop !== 1'b0) begin errors++; $display("[TB] FAIL basic_pop1 got %b%b exp 10", vc0_pop, vc1_pop); end
        advance(); @(negedge clk);
        checks++; if (vc0_pop !== 1'b1) begin errors++; $display("[TB] FAIL basic_pop2 got %b exp 1", vc0_pop); end
        checks++; if (d0_push !== 1'b1 || d0_data !== 6'b000001 || d1_push !== 1'b0) begin errors++; $display("[TB] FAIL basic_push1 got %b %b exp 1 000001", d0_push, d0_data); end
        checks++; if (last_grant !== 2'b01) begin errors++; $display("[TB] FAIL basic_last1 got %b exp 01", last_grant); end
        advance(); @(negedge clk);
        checks++; if (vc0_pop !== 1'b0) begin errors++; $display("[TB] FAIL basic_pop_empty got %b exp 0", vc0_pop); end
        checks++; if (d0_push !== 1'b1 || d0_data !== 6'b000010) begin errors++; $display("[TB] FAIL basic_push2 got %b %b exp 1 000010", d0_push, d0_data); end
        advance(); @(negedge clk);
        checks++; if (d0_push !== 1'b0 || d0_data !== 6'b000010 || last_grant !== 2'b00) begin errors++; $display("[TB] FAIL basic_idle got %b %b %b exp 0 000010 00", d0_push, d0_data, last_grant); end
    endtask

    task automatic test_priority();
        q0.push_back(6'b010011);
        q1.push_back(6'b000100);
        drive();
        @(negedge clk);
        checks++; if (vc0_pop !== 1'b1 || vc1_pop !== 1'b0) begin errors++; $display("[TB] FAIL prio_pop got %b%b exp 10", vc0_pop, vc1_pop); end
        advance(); @(negedge clk);
        checks++; if (d1_push !== 1'b1 || d1_data !== 6'b010011 || d0_push !== 1'b0) begin errors++; $display("[TB] FAIL prio_d1 got %b %b d0p %b exp 1 010011 0", d1_push, d1_data, d0_push); end
        checks++; if (vc1_pop !== 1'b1) begin errors++; $display("[TB] FAIL prio_vc1_pop got %b exp 1", vc1_pop); end
        advance(); @(negedge clk);
        checks++; if (d0_push !== 1'b1 || d0_data !== 6'b000100 || d1_push !== 1'b0) begin errors++; $display("[TB] FAIL prio_d0 got %b %b d1p %b exp 1 000100 0", d0_push, d0_data, d1_push); end
        checks++; if (last_grant !== 2'b10) begin errors++; $display("[TB] FAIL prio_last got %b exp 10", last_grant); end
        drain();
    endtask

    task automatic test_bypass();
        af1 = 1'b1;
        q0.push_back(6'b010001);
        q1.push_back(6'b100010);
        drive();
        @(negedge clk);
        checks++; if (vc0_pop !== 1'b0 || vc1_pop !== 1'b1) begin errors++; $display("[TB] FAIL bypass_pop got %b%b exp 01", vc0_pop, vc1_pop); end
        advance(); @(negedge clk);
        checks++; if (d0_push !== 1'b1 || d0_data !== 6'b100010) begin errors++; $display("[TB] FAIL bypass_d0 got %b %b exp 1 100010", d0_push, d0_data); end
        checks++; if (vc0_pop !== 1'b0) begin errors++; $display("[TB] FAIL bypass_hold got %b exp 0", vc0_pop); end
        af1 = 1'b0;
        drive();
        #1;
        checks++; if (vc0_pop !== 1'b1) begin errors++; $display("[TB] FAIL bypass_release got %b exp 1", vc0_pop); end
        advance(); @(negedge clk);
        checks++; if (d1_push !== 1'b1 || d1_data !== 6'b010001) begin errors++; $display("[TB] FAIL bypass_d1 got %b %b exp 1 010001", d1_push, d1_data); end
        drain();
    endtask

    task automatic test_pause();
        af0 = 1'b1; af1 = 1'b1;
        q0.push_back(6'b010001);
        q1.push_back(6'b000010);
        drive();
        advance(); advance(); @(negedge clk);
        checks++; if (vc0_pop !== 1'b0 || vc1_pop !== 1'b0) begin errors++; $display("[TB] FAIL pause_pop got %b%b exp 00", vc0_pop, vc1_pop); end
        checks++; if (d0_push !== 1'b0 || d1_push !== 1'b0 || last_grant !== 2'b00) begin errors++; $display("[TB] FAIL pause_push got %b%b %b exp 00 00", d0_push, d1_push, last_grant); end
        af0 = 1'b0;
        drive();
        #1;
        checks++; if (vc0_pop !== 1'b0 || vc1_pop !== 1'b1) begin errors++; $display("[TB] FAIL pause_resume got %b%b exp 01", vc0_pop, vc1_pop); end
        advance(); @(negedge clk);
        checks++; if (d0_push !== 1'b1 || d0_data !== 6'b000010 || d1_push !== 1'b0 || vc0_pop !== 1'b0) begin errors++; $display("[TB] FAIL pause_d0 got %b %b %b %b exp 1 000010 0 0", d0_push, d0_data, d1_push, vc0_pop); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[10];
        for (int i = 0; i < 10; i++) begin
            words[i] = W'($urandom);
            q0.push_back(words[i]);
        end
        drive();
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) begin
                checks++; if (vc0_pop !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pop[%0d] got %b exp 1", i, vc0_pop); end
            end
            if (i > 0) begin
                checks++;
                if ((words[i-1][DB] ? {d1_push, d1_data} : {d0_push, d0_data}) !== {1'b1, words[i-1]}) begin
                    errors++; $display("[TB] FAIL b2b_push[%0d] got d0 %b/%b d1 %b/%b exp word %b", i, d0_push, d0_data, d1_push, d1_data, words[i-1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (vc0_pop !== (exp_g == 1) || vc1_pop !== (exp_g == 2)) begin
                errors++; $display("[TB] FAIL rand_pop[%0d] got %b%b exp grant %0d", c, vc0_pop, vc1_pop, exp_g);
            end
            checks++;
            if ({d0_push, d0_data, d1_push, d1_data} !== {m_d0_push, m_d0_data, m_d1_push, m_d1_data}) begin
                errors++; $display("[TB] FAIL rand_out[%0d] got %b/%b %b/%b exp %b/%b %b/%b", c, d0_push, d0_data, d1_push, d1_data, m_d0_push, m_d0_data, m_d1_push, m_d1_data);
            end
            checks++;
            if (last_grant !== m_last) begin errors++; $display("[TB] FAIL rand_last[%0d] got %b exp %b", c, last_grant, m_last); end
            advance();
            if ($urandom_range(0, 2) != 0 && q0.size() < 8) q0.push_back(W'($urandom));
            if ($urandom_range(0, 2) != 0 && q1.size() < 8) q1.push_back(W'($urandom));
            af0 = ($urandom_range(0, 3) == 0);
            af1 = ($urandom_range(0, 3) == 0);
            drive();
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) q0.push_back(6'b000111);
        drive();
        advance();
        @(negedge clk);
        reset = 1'b1;
        drive();
        #1;
        checks++; if (d0_push !== 1'b0 || d1_push !== 1'b0) begin errors++; $display("[TB] FAIL mid_push got %b%b exp 00", d0_push, d1_push); end
        checks++; if (d0_data !== 6'd0 || d1_data !== 6'd0 || last_grant !== 2'b00) begin errors++; $display("[TB] FAIL mid_state got %b %b %b exp 0 0 00", d0_data, d1_data, last_grant); end
        checks++; if (vc0_pop !== 1'b0) begin errors++; $display("[TB] FAIL mid_pop got %b exp 0", vc0_pop); end
        advance();
        reset = 1'b0;
        q0.delete(); q1.delete();
        drive();
        @(negedge clk);
        checks++; if (d0_push !== 1'b0 || last_grant !== 2'b00) begin errors++; $display("[TB] FAIL mid_after got %b %b exp 0 00", d0_push, last_grant); end
    endtask

    task automatic test_starve();
        int n1;
        int exp_n1;
        logic exp_pop1;
        n1 = 0;
        for (int i = 0; i < 20; i++) q0.push_back(W'(i + 1));
        for (int i = 0; i < 5; i++)  q1.push_back(W'(32 + i));
        drive();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
`ifdef VC_ARB_STARVE_GUARD_EN
            exp_pop1 = ((i % 8) == 7);
`else
            exp_pop1 = 1'b0;
`endif
            if (vc1_pop === 1'b1) n1++;
            checks++;
            if (vc1_pop !== exp_pop1 || vc0_pop !== !exp_pop1) begin
                errors++; $display("[TB] FAIL starve_grant[%0d] got %b%b exp %b%b", i, vc0_pop, vc1_pop, !exp_pop1, exp_pop1);
            end
            advance();
        end
`ifdef VC_ARB_STARVE_GUARD_EN
        exp_n1 = 2;
`else
        exp_n1 = 0;
`endif
        checks++; if (n1 != exp_n1) begin errors++; $display("[TB] FAIL starve_count got %0d exp %0d", n1, exp_n1); end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_bypass();
        test_pause();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        test_starve();
        checks++;
        if (q0.size() + q1.size() != 0) begin errors++; $display("[TB] FAIL drain_timeout got %0d left exp 0", q0.size() + q1.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
